glb_iact_bank: RTL and testbench

Global-buffer bank for input activations. It sits directly upstream of the west iact router: it serves that router's `west_req_read`/`west_addr_read` requests with registered read data. It is filled from the off-chip activation stream through a valid/ready port, under a small fill FSM. Reads always win the single memory port; fill traffic is back-pressured while a read is in flight.

---
 rtl/glb_iact_bank.sv | 105 ++++++++++
 tb/tb_glb_iact_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/glb_iact_bank.sv
// Input-activation global-buffer bank: single-port storage, fill FSM on a
// valid/ready stream, and registered reads that always win the port.
module glb_iact_bank #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            fill_start,
    input  logic [ADDR_BITWIDTH-1:0]        fill_base,
    input  logic [ADDR_BITWIDTH:0]          fill_len,
    input  logic [DATA_BITWIDTH-1:0]        fill_data,
    input  logic                            fill_valid,
    output logic                            fill_ready,
    output logic                            fill_done,
    output logic                            busy,
    input  logic                            read_req,
    input  logic [ADDR_BITWIDTH-1:0]        read_addr,
    output logic signed [DATA_BITWIDTH-1:0] read_data,
    output logic                            read_valid
);

    localparam int DEPTH = 1 << ADDR_BITWIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [ADDR_BITWIDTH-1:0]   r_wr_ptr;
    logic [ADDR_BITWIDTH:0]     r_remaining;
    logic [DATA_BITWIDTH-1:0]   r_mem [0:DEPTH-1];
    logic [DATA_BITWIDTH-1:0]   r_read_data;
    logic                       r_read_valid;
    logic                       w_xfer;
    logic                       w_start;
    logic                       w_last;

    localparam logic [ADDR_BITWIDTH:0] ONE = {{ADDR_BITWIDTH{1'b0}}, 1'b1};

    // A start is only honoured outside FILL; a restart mid-fill is dropped.
    assign w_start    = fill_start && (r_state != S_FILL);
    assign fill_ready = (r_state == S_FILL) && !read_req;
    assign w_xfer     = fill_valid && fill_ready;
    assign w_last     = (r_remaining == ONE);
    assign fill_done  = (r_state == S_DONE);
    assign busy       = (r_state == S_FILL);
    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;

    // State register for the fill FSM.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; zero-length fills go straight to DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (fill_start)
                    w_state_nxt = (fill_len != '0) ? S_FILL : S_DONE;
            end
            S_FILL: begin
                if (w_xfer && w_last) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Write pointer and word countdown for the active fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_remaining <= '0;
        end else if (w_start) begin
            r_wr_ptr    <= fill_base;
            r_remaining <= fill_len;
        end else if (w_xfer) begin
            r_wr_ptr    <= r_wr_ptr + 1'b1;
            r_remaining <= r_remaining - ONE;
        end
    end

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_xfer && !reset) r_mem[r_wr_ptr] <= fill_data;
    end

    // Registered read port; data holds when no read is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
        end else begin
            r_read_valid <= read_req;
            if (read_req) r_read_data <= r_mem[read_addr];
        end
    end

endmodule

// File: tb/tb_glb_iact_bank.sv
// Directed self-checking bench for glb_iact_bank.
// Inputs change 1ns after rising edges; combinational outputs are sampled at falling edges.
module tb_glb_iact_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        fill_start;
    logic [9:0]  fill_base;
    logic [10:0] fill_len;
    logic [15:0] fill_data;
    logic        fill_valid;
    logic        fill_ready;
    logic        fill_done;
    logic        busy;
    logic        read_req;
    logic [9:0]  read_addr;
    logic [15:0] read_data;
    logic        read_valid;

    int n_chk  = 0;
    int n_pass = 0;
    logic [15:0] wq [0:7];

    glb_iact_bank #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH(10)) dut (
        .clk(clk), .reset(reset),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
        .fill_data(fill_data), .fill_valid(fill_valid), .fill_ready(fill_ready),
        .fill_done(fill_done), .busy(busy),
        .read_req(read_req), .read_addr(read_addr),
        .read_data(read_data), .read_valid(read_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fill(input logic [9:0] base, input logic [10:0] len);
        fill_start = 1'b1;
        fill_base  = base;
        fill_len   = len;
        tick();
        fill_start = 1'b0;
    endtask

    // Streams wq[first..first+n-1], returns edges spent (bounded).
    task automatic stream(input int first, input int n, output int cycles);
        int i;
        logic acc;
        i = 0;
        cycles = 0;
        while (i < n && cycles < 50) begin
            fill_valid = 1'b1;
            fill_data  = wq[first+i];
            @(negedge clk);
            acc = fill_ready;
            tick();
            cycles++;
            if (acc) i++;
        end
        fill_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [9:0] a,
                      input logic [15:0] exp);
        read_req  = 1'b1;
        read_addr = a;
        tick();
        read_req  = 1'b0;
        chk({tag, "_v"}, 32'(read_valid), 32'd1);
        chk(tag, 32'(read_data), 32'(exp));
    endtask

    initial begin
        int cyc;
        int idx;
        reset = 1'b1; fill_start = 0; fill_base = 0; fill_len = 0;
        fill_data = 0; fill_valid = 0; read_req = 0; read_addr = 0;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(fill_ready), 0);
        chk("rst_done", 32'(fill_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rvalid", 32'(read_valid), 0);
        chk("rst_rdata", 32'(read_data), 0);

        // Preload base 0 with known words.
        tick();
        for (int k = 0; k < 8; k++) wq[k] = 16'h0A00 + 16'(k);
        start_fill(10'd0, 11'd8);
        stream(0, 8, cyc);
        chk("pre_cycles", 32'(cyc), 32'd8);

        // Idle with valid data but no start: nothing accepted.
        fill_valid = 1'b1;
        fill_data  = 16'hDEAD;
        start_fill(10'd0, 11'd0);
        fill_valid = 1'b1;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_ready", 32'(fill_ready), 0);
            tick();
        end
        fill_valid = 1'b0;
        rd("idle_nowrite", 10'd0, 16'h0A00);

        // Basic fill at 100.
        for (int k = 0; k < 5; k++) wq[k] = 16'(11 + k);
        start_fill(10'd100, 11'd5);
        chk("basic_busy", 32'(busy), 1);
        chk("basic_done0", 32'(fill_done), 0);
        stream(0, 5, cyc);
        chk("basic_cycles", 32'(cyc), 32'd5);
        chk("basic_done", 32'(fill_done), 1);
        for (int k = 0; k < 5; k++) begin
            read_req  = 1'b1;
            read_addr = 10'(100 + k);
            tick();
            chk("b2b_v", 32'(read_valid), 1);
            chk("b2b_d", 32'(read_data), 32'(11 + k));
        end
        read_req = 1'b0;
        tick();
        chk("rd_idle_v", 32'(read_valid), 0);
        chk("rd_hold", 32'(read_data), 32'd15);

        // Read priority stalls the fill for exactly two cycles.
        for (int k = 0; k < 4; k++) wq[k] = 16'h0B00 + 16'(k);
        start_fill(10'd200, 11'd4);
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            read_req   = (c == 1 || c == 2);
            read_addr  = 10'd101;
            fill_valid = 1'b1;
            fill_data  = wq[idx];
            @(negedge clk);
            chk("bp_ready", 32'(fill_ready), 32'(!read_req));
            if (c == 5) chk("bp_busy_late", 32'(busy), 1);
            if (fill_ready) idx++;
            tick();
            if (c == 1 || c == 2) chk("bp_rd", 32'(read_data), 32'd12);
        end
        read_req = 1'b0; fill_valid = 1'b0;
        chk("bp_count", 32'(idx), 32'd4);
        chk("bp_done", 32'(fill_done), 1);
        for (int k = 0; k < 4; k++)
            rd("bp_rb", 10'(200 + k), 16'h0B00 + 16'(k));

        // Wrap-around from 1022.
        wq[0] = 16'h00AA; wq[1] = 16'h00BB; wq[2] = 16'h00CC; wq[3] = 16'h00DD;
        start_fill(10'd1022, 11'd4);
        stream(0, 4, cyc);
        chk("wrap_done", 32'(fill_done), 1);
        rd("wrap_1022", 10'd1022, 16'h00AA);
        rd("wrap_1023", 10'd1023, 16'h00BB);
        rd("wrap_0", 10'd0, 16'h00CC);
        rd("wrap_1", 10'd1, 16'h00DD);

        // Zero length goes straight to DONE.
        reset = 1'b1; tick(); reset = 1'b0;
        fill_valid = 1'b1;
        start_fill(10'd500, 11'd0);
        @(negedge clk);
        chk("zero_done", 32'(fill_done), 1);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_ready", 32'(fill_ready), 0);
        tick();
        fill_valid = 1'b0;

        // Restart mid-fill is ignored.
        wq[0] = 16'h0C00; wq[1] = 16'h0C01; wq[2] = 16'h0C02;
        start_fill(10'd300, 11'd3);
        fill_valid = 1'b1; fill_data = wq[0];
        fill_start = 1'b1; fill_base = 10'd400; fill_len = 11'd2;
        tick();
        fill_start = 1'b0;
        stream(1, 1, cyc);
        chk("rs_busy", 32'(busy), 1);
        stream(2, 1, cyc);
        chk("rs_done", 32'(fill_done), 1);
        rd("rs_300", 10'd300, 16'h0C00);
        rd("rs_301", 10'd301, 16'h0C01);
        rd("rs_302", 10'd302, 16'h0C02);

        // Reset mid-fill keeps written words only.
        for (int k = 0; k < 6; k++) wq[k] = 16'h0D00 + 16'(k);
        start_fill(10'd0, 11'd6);
        stream(0, 2, cyc);
        reset = 1'b1; tick(); reset = 1'b0;
        @(negedge clk);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_done", 32'(fill_done), 0);
        chk("mr_ready", 32'(fill_ready), 0);
        tick();
        rd("mr_a1", 10'd1, 16'h0D01);
        rd("mr_a2", 10'd2, 16'h0A02);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
